// File: rtl/ps2_kbd_slave.sv
// ps2_kbd_slave: PS/2 keyboard receiver with a scan-code FIFO, exposed as a
// bus slave on the CPU data bus.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   ps2_clk/data   raw PS/2 lines from the keyboard (asynchronous)
//   stb, we, addr  bus strobe (already address-decoded), write enable, offset
//   data_i         bus write data
//   data_o         registered bus read data, valid while ack=1
//   ack            one-cycle acknowledge, one per access
//
// Register map (addr[3:2]):
//   0 DATA    read pops FIFO head into [7:0] (0 when empty); writes ignored
//   1 STATUS  bit0 not-empty, bit1 ovf, bit2 perr, [15:8] count
//   2 CTRL    write bit0 clears ovf/perr, bit1 flushes FIFO; reads 0
//   3 -       reads 0, writes ignored
module ps2_kbd_slave #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // ---------------- synchronisers and edge detect ----------------
  logic [1:0] kclk_sync, kdat_sync;
  logic       kclk_prev;
  logic       fall, bit_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kclk_sync <= 2'b11;
      kdat_sync <= 2'b11;
      kclk_prev <= 1'b1;
    end else begin
      kclk_sync <= {kclk_sync[0], ps2_clk};
      kdat_sync <= {kdat_sync[0], ps2_data};
      kclk_prev <= kclk_sync[1];
    end
  end

  assign fall   = kclk_prev & ~kclk_sync[1];
  assign bit_in = kdat_sync[1];

  // ---------------- frame receiver ----------------
  typedef enum logic [1:0] {IDLE, RECV, CHECK} rx_state_t;

  rx_state_t        state;
  logic [9:0]       shreg;   // {stop, parity, data[7:0]} once the frame is in
  logic [3:0]       bitcnt;
  logic [TW-1:0]    tmo;
  logic             frame_ok, push, perr_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      tmo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall && !bit_in) begin
            state  <= RECV;
            bitcnt <= '0;
            tmo    <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shreg <= {bit_in, shreg[9:1]};
            tmo   <= '0;
            if (bitcnt == 4'd9) state <= CHECK;
            else                bitcnt <= bitcnt + 4'd1;
          end else if (tmo == TO_MAX) begin
            state <= IDLE;           // stalled keyboard: drop partial frame silently
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Odd parity over data+parity, and the stop bit must be high.
  assign frame_ok = (^shreg[8:0]) & shreg[9];
  assign push     = (state == CHECK) & frame_ok;
  assign perr_set = (state == CHECK) & ~frame_ok;

  // ---------------- bus decode ----------------
  logic        access, pop, flush, clr;
  logic [1:0]  sel;
  logic [31:0] rd_word;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        ovf, perr;
  logic        full, push_ok, ovf_set;
  logic [7:0]  count8;
  logic        unused;

  assign unused = ^{addr[1:0], data_i[31:2]};

  // The access takes effect at the edge that raises ack.
  assign access = stb & ~ack;
  assign sel    = addr[3:2];
  assign pop    = access & ~we & (sel == 2'd0) & (count != '0);
  assign flush  = access &  we & (sel == 2'd2) & data_i[1];
  assign clr    = access &  we & (sel == 2'd2) & data_i[0];
  assign count8 = 8'(count);

  always_comb begin
    rd_word = '0;
    case (sel)
      2'd0: if (count != '0) rd_word[7:0] = mem[rd_ptr];
      2'd1: rd_word = {16'd0, count8, 5'd0, perr, ovf, count != '0};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack    <= 1'b0;
      data_o <= '0;
    end else begin
      ack <= access;
      if (access) data_o <= we ? 32'd0 : rd_word;
    end
  end

  // ---------------- FIFO ----------------
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign full    = (count == FULL_CNT);
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= shreg[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      perr   <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (!push_ok && pop) count <= count - CW'(1);
      end
      // Set events take priority over a coincident clear.
      if (ovf_set)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
      if (perr_set) perr <= 1'b1;
      else if (clr) perr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_slave.sv
// Randomized bench for ps2_kbd_slave against a queue-based reference model.
module tb_ps2_kbd_slave;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 10;

  logic        clk = 0, reset = 1;
  logic        ps2_clk = 1, ps2_data = 1;
  logic        stb = 0, we = 0;
  logic [3:0]  addr = 0;
  logic [31:0] data_i = 0;
  logic [31:0] data_o;
  logic        ack;

  ps2_kbd_slave #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .stb(stb), .we(we), .addr(addr), .data_i(data_i),
    .data_o(data_o), .ack(ack)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // reference model
  logic [7:0] q[$];
  bit m_ovf = 0, m_perr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [31:0] exp_status();
    logic [7:0] c;
    c = 8'(q.size());
    return {16'd0, c, 5'd0, m_perr, m_ovf, q.size() != 0};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_perr = 0;
  endtask

  // single access: ack must rise exactly one cycle after stb, then fall
  task automatic bus(input bit w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    @(posedge clk); #1;
    stb = 1; we = w; addr = a; data_i = d;
    @(posedge clk); #1;
    chk("ack_rise", {31'd0, ack}, 32'd1);
    r = data_o;
    stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_fall", {31'd0, ack}, 32'd0);
  endtask

  task automatic rd_data();
    logic [31:0] r, e;
    bus(0, 4'h0, 32'd0, r);
    e = (q.size() != 0) ? {24'd0, q.pop_front()} : 32'd0;
    chk("data", r, e);
  endtask

  task automatic rd_status();
    logic [31:0] r;
    bus(0, 4'h4, 32'd0, r);
    chk("status", r, exp_status());
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    logic [31:0] r;
    bus(1, 4'h8, d, r);
    if (d[1]) q.delete();
    if (d[0]) begin m_ovf = 0; m_perr = 0; end
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 0;
    cyc(HALF);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] v, input bit bad_par, input bit bad_stop);
    bit p;
    p = (~^v) ^ bad_par;
    ps2_bit(0);
    for (int i = 0; i < 8; i++) ps2_bit(v[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    ps2_data = 1;
    cyc(HALF);
    if (bad_par || bad_stop) m_perr = 1;
    else if (q.size() == DEPTH) m_ovf = 1;
    else q.push_back(v);
  endtask

  task automatic partial(input int nbits);
    ps2_bit(0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1;
  endtask

  // stb held across two DATA reads: ack must go 0,1,0,1
  task automatic b2b_reads();
    logic [31:0] e0, e1;
    e0 = {24'd0, q.pop_front()};
    e1 = {24'd0, q.pop_front()};
    @(posedge clk); #1;
    stb = 1; we = 0; addr = 4'h0;
    @(posedge clk); #1;
    chk("b2b_ack1", {31'd0, ack}, 32'd1);
    chk("b2b_data1", data_o, e0);
    @(posedge clk); #1;
    chk("b2b_gap", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_ack2", {31'd0, ack}, 32'd1);
    chk("b2b_data2", data_o, e1);
    stb = 0;
    @(posedge clk); #1;
    chk("b2b_end", {31'd0, ack}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    cyc(3); #1;
    reset = 0;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    rd_status();

    // single good frame
    send_frame(8'h1C, 0, 0);
    rd_status();
    rd_data();
    rd_status();

    // parity error, then clear
    send_frame(8'h1C, 1, 0);
    rd_status();
    wr_ctrl(32'h1);
    rd_status();

    // overflow and pointer wrap
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    rd_status();
    for (int i = 0; i < 8; i++) rd_data();
    wr_ctrl(32'h1);
    for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + i), 0, 0);
    rd_status();
    for (int i = 0; i < 8; i++) rd_data();
    rd_data();                       // empty read
    rd_status();

    // back-to-back reads
    send_frame(8'h01, 0, 0);
    send_frame(8'h02, 0, 0);
    b2b_reads();
    rd_status();

    // timeout discards partial frame
    partial(4);
    cyc(TMO + 20);
    send_frame(8'h5A, 0, 0);
    rd_status();
    rd_data();
    rd_status();

    // unused offsets / ignored writes
    bus(0, 4'hC, 32'd0, r);  chk("off_c", r, 32'd0);
    bus(0, 4'h8, 32'd0, r);  chk("ctrl_rd", r, 32'd0);
    send_frame(8'hA5, 0, 0);
    bus(1, 4'h0, 32'hFF, r);
    bus(1, 4'hC, 32'h3, r);
    rd_status();

    // reset mid-frame
    partial(5);
    #3 reset = 1;
    model_reset();
    ps2_clk = 1; ps2_data = 1;
    cyc(2); #1 reset = 0;
    rd_status();
    send_frame(8'h33, 0, 0);
    rd_status();
    rd_data();

    // reset mid-access: ack drops asynchronously
    send_frame(8'h44, 0, 0);
    @(posedge clk); #1;
    stb = 1; addr = 4'h4;
    @(posedge clk); #1;
    chk("pre_rst_ack", {31'd0, ack}, 32'd1);
    reset = 1;
    model_reset();
    #1;
    chk("async_ack", {31'd0, ack}, 32'd0);
    chk("async_data", data_o, 32'd0);
    stb = 0;
    cyc(2); #1 reset = 0;
    rd_status();

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        bit bad;
        bad = ($urandom_range(0, 5) == 0);
        if (bad && $urandom_range(0, 1)) send_frame(8'($urandom), 0, 1);
        else                             send_frame(8'($urandom), bad, 0);
      end else if (op <= 5) rd_data();
      else if (op == 6)     rd_status();
      else if (op == 7) begin
        if ($urandom_range(0, 3) == 0) wr_ctrl(32'($urandom_range(0, 3)));
        else                           wr_ctrl(32'h1);
      end else if (op == 8) begin
        bus(0, 4'($urandom_range(2, 3) << 2), 32'd0, r);
        chk("rand_zero", r, 32'd0);
      end else begin
        bus(1, 4'h0, $urandom, r);
        rd_status();
      end
    end
    rd_status();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_slave.md
Name: ps2_kbd_slave

Overview:
- Keyboard I/O slave on the CPU data bus (Addr/Data_I/Data_O/WE/STB/ACK).
- Receives PS/2 scan-code frames and buffers the bytes in a FIFO.
- Answers CPU lw/sw accesses with a one-cycle ACK pulse, which stalls the CPU pc until the slave responds.
- Sits downstream of the CPU, behind the address decoder that gates stb for the keyboard region.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, range 2..128.
- TIMEOUT, 100000, clk cycles without a ps2 falling edge mid-frame before the receiver aborts (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from keyboard (asynchronous)
- ps2_data  input  1  raw PS/2 data from keyboard (asynchronous)
- stb  input  1  bus strobe, already qualified by the keyboard address decode
- we  input  1  bus write enable
- addr  input  4  byte offset within the slave; bits [3:2] used
- data_i  input  32  bus write data (CPU Data_O)
- data_o  output  32  bus read data (CPU Data_I)
- ack  output  1  bus acknowledge, one-cycle pulse

Behaviour:
- Reset (async) clears: data_o=0, ack=0, FIFO empty, count=0, ovf=0, perr=0, receiver IDLE, sync flops=1.
- Register map:
  - 0x0 DATA: read pops FIFO head into data_o[7:0], upper bits 0; if empty, reads 0 with no pop; writes are ignored.
  - 0x4 STATUS (read-only): bit0 = not-empty, bit1 = ovf, bit2 = perr, bits[15:8] = count, others 0.
  - 0x8 CTRL (write): bit0=1 clears ovf and perr; bit1=1 flushes FIFO (count=0); reads return 0.
  - 0xC: reads 0, writes ignored.
- Bus handshake:
  - ack_next = stb & ~ack, registered.
  - Access presented in cycle N gets ack=1 in cycle N+1, held for exactly 1 cycle, with data_o valid that same cycle.
  - data_o is registered and updated at the edge that raises ack; it holds its value otherwise.
  - Back-to-back accesses with stb held high alternate ack 0,1,0,1; each ack completes exactly one access.
  - Every access is acked, including empty reads and unused offsets.
  - The pop and any CTRL side effect occur at the edge that raises ack; we/addr/data_i are sampled at that edge.
- PS/2 receiver:
  - ps2_clk and ps2_data each pass through 2-flop synchronisers.
  - A falling edge is detected from synced clk previous=1, current=0.
  - States: IDLE, RECV, CHECK.
  - IDLE: falling edge with data=0 (start bit) -> RECV, bitcnt=0. A falling edge with data=1 is ignored.
  - RECV: each falling edge shifts data in LSB-first. Bits 0..7 are data, bit 8 is parity, bit 9 is stop. After the stop bit -> CHECK.
  - CHECK (1 cycle): the frame is valid if the 9 bits (data+parity) have odd weight and stop=1.
    - Valid frame: push the byte.
    - Invalid frame: discard and set perr (sticky).
    - Always return to IDLE.
  - Timeout: in RECV, a counter resets on every falling edge. When it reaches TIMEOUT-1 -> IDLE, partial frame discarded, no flag set.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits that wrap naturally; separate count register 0..FIFO_DEPTH.
  - Push when full: byte dropped, ovf set (sticky), contents unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged, including when full (no ovf) and when empty (pop takes nothing, push succeeds, count=1).
  - Flush coincident with push: flush wins, count=0.
  - CTRL clear coincident with an ovf/perr set event: the set wins.
- Reset mid-frame or mid-access: everything returns to the reset state immediately; ack drops asynchronously.

Test Plan:
- Read STATUS after reset, FIFO empty: stb=1, we=0, addr=0x4 -> ack=1 one cycle later, data_o=0x00000000; pc-style stall exactly 1 cycle.
- Send PS/2 frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1: start, data LSB-first, parity 0, stop) -> STATUS=0x00000101; DATA read returns 0x0000001C; following STATUS=0x00000000.
- Send 0x1C with parity bit forced to 1 -> FIFO stays empty, STATUS=0x00000004; write CTRL data_i=0x1 -> STATUS=0x00000000.
- Send 9 valid frames 0x01..0x09 with FIFO_DEPTH=8 -> STATUS=0x00000803; 8 DATA reads return 0x01..0x08 in order, with pointer wrap exercised by a second 8-frame burst.
- Hold stb=1 for two consecutive DATA reads with 2 bytes queued -> ack pattern 0,1,0,1; data_o=0x01 then 0x02; exactly 2 pops.
- Send start + 4 data bits, then idle for TIMEOUT cycles; then a full frame 0x5A -> partial frame discarded without flags; FIFO holds only 0x5A. Assert reset mid-frame -> all state cleared and the next full frame is received correctly.
